// File: rtl/uctl_linestatemonitor.sv
// USB line state monitor: times qualified line conditions from the glitch filter
// and reports bus reset, suspend and resume to the link/power controller.
module uctl_linestatemonitor #(
  parameter int unsigned CNTR_WD = 20
) (
  input  logic               aon_clk,
  input  logic               aon_rst_n,
  input  logic               sw_rst,
  input  logic [1:0]         line_state,
  input  logic               stable,
  input  logic [CNTR_WD-1:0] se0_time,
  input  logic [CNTR_WD-1:0] idle_time,
  input  logic [CNTR_WD-1:0] k_time,
  output logic               bus_reset,
  output logic               suspend_det,
  output logic               resume_det,
  output logic [2:0]         lm_state
);

  localparam logic [1:0] LsSe0 = 2'b00;
  localparam logic [1:0] LsK   = 2'b01;
  localparam logic [1:0] LsJ   = 2'b10;

  typedef enum logic [2:0] {
    StActive     = 3'd0,
    StSe0Wait    = 3'd1,
    StRstHold    = 3'd2,
    StIdleWait   = 3'd3,
    StSuspend    = 3'd4,
    StResumeWait = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNTR_WD-1:0] cnt_q, cnt_d;
  logic               bus_reset_q, bus_reset_d;
  logic               suspend_q, suspend_d;
  logic               resume_q, resume_d;
  logic               cnt_inc;

  logic q_se0, q_j, q_k, q_non_se0, cnt_sat;

  assign q_se0     = stable && (line_state == LsSe0);
  assign q_j       = stable && (line_state == LsJ);
  assign q_k       = stable && (line_state == LsK);
  assign q_non_se0 = stable && (line_state != LsSe0);
  assign cnt_sat   = &cnt_q;

  // Next-state, event and duration-counter logic.
  always_comb begin
    state_d     = state_q;
    bus_reset_d = 1'b0;
    resume_d    = 1'b0;
    suspend_d   = suspend_q;
    cnt_inc     = 1'b0;

    unique case (state_q)
      StActive: begin
        if (q_se0) begin
          state_d = StSe0Wait;
        end else if (q_j) begin
          state_d = StIdleWait;
        end
      end
      StSe0Wait: begin
        if (!q_se0) begin
          // SE0 ended early; any activity also ends a suspend that led here.
          state_d   = StActive;
          suspend_d = 1'b0;
        end else if ((se0_time != '0) && (cnt_q == se0_time)) begin
          state_d     = StRstHold;
          bus_reset_d = 1'b1;
          suspend_d   = 1'b0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StRstHold: begin
        if (q_non_se0) begin
          state_d = StActive;
        end
      end
      StIdleWait: begin
        if (!q_j) begin
          state_d = StActive;
        end else if ((idle_time != '0) && (cnt_q == idle_time)) begin
          state_d   = StSuspend;
          suspend_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StSuspend: begin
        if (q_k) begin
          state_d = StResumeWait;
        end else if (q_se0) begin
          state_d = StSe0Wait;
        end
      end
      StResumeWait: begin
        if (!q_k) begin
          state_d = StSuspend;
        end else if ((k_time != '0) && (cnt_q == k_time)) begin
          state_d   = StActive;
          resume_d  = 1'b1;
          suspend_d = 1'b0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d   = StActive;
        suspend_d = 1'b0;
      end
    endcase

    // Counter restarts on every transition and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_inc && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and registered outputs; sw_rst overrides everything.
  always_ff @(posedge aon_clk or negedge aon_rst_n) begin
    if (!aon_rst_n) begin
      state_q     <= StActive;
      cnt_q       <= '0;
      bus_reset_q <= 1'b0;
      suspend_q   <= 1'b0;
      resume_q    <= 1'b0;
    end else if (sw_rst) begin
      state_q     <= StActive;
      cnt_q       <= '0;
      bus_reset_q <= 1'b0;
      suspend_q   <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_reset_q <= bus_reset_d;
      suspend_q   <= suspend_d;
      resume_q    <= resume_d;
    end
  end

  assign bus_reset   = bus_reset_q;
  assign suspend_det = suspend_q;
  assign resume_det  = resume_q;
  assign lm_state    = state_q;

endmodule

// File: tb/tb_uctl_linestatemonitor.sv
// Directed scenarios plus a random walk of the line, checked every cycle against
// a behavioural model of the line state monitor.
module tb_uctl_linestatemonitor;

  localparam int unsigned W    = 8;
  localparam int          MAXC = (1 << W) - 1;

  // Debug state numbers as seen on lm_state.
  localparam int MActive = 0, MSe0Wait = 1, MRstHold = 2;
  localparam int MIdleWait = 3, MSuspend = 4, MResumeWait = 5;

  logic         aon_clk;
  logic         aon_rst_n;
  logic         sw_rst;
  logic [1:0]   line_state;
  logic         stable;
  logic [W-1:0] se0_time, idle_time, k_time;
  logic         bus_reset, suspend_det, resume_det;
  logic [2:0]   lm_state;

  int errors;
  int checks;

  // Model: which condition is being timed, and how many qualified cycles of it
  // have been seen since the timing began (unbounded; saturation at compare).
  int m_state;
  int m_run;
  bit m_susp, m_rst, m_res;

  uctl_linestatemonitor #(.CNTR_WD(W)) dut (
    .aon_clk    (aon_clk),
    .aon_rst_n  (aon_rst_n),
    .sw_rst     (sw_rst),
    .line_state (line_state),
    .stable     (stable),
    .se0_time   (se0_time),
    .idle_time  (idle_time),
    .k_time     (k_time),
    .bus_reset  (bus_reset),
    .suspend_det(suspend_det),
    .resume_det (resume_det),
    .lm_state   (lm_state)
  );

  initial aon_clk = 1'b0;
  always #5 aon_clk = ~aon_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit reached(input logic [W-1:0] thr);
    int seen;
    seen = (m_run > MAXC) ? MAXC : m_run;
    return (thr != '0) && (seen == int'(thr));
  endfunction

  function automatic void model_clear();
    m_state = MActive;
    m_run   = 0;
    m_susp  = 1'b0;
    m_rst   = 1'b0;
    m_res   = 1'b0;
  endfunction

  function automatic void model_go(input int s);
    m_state = s;
    m_run   = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  function automatic void model_step();
    bit se0, j, k;
    se0   = stable && (line_state == 2'b00);
    j     = stable && (line_state == 2'b10);
    k     = stable && (line_state == 2'b01);
    m_rst = 1'b0;
    m_res = 1'b0;
    if (!aon_rst_n || sw_rst) begin
      model_clear();
      return;
    end
    if (m_state == MActive) begin
      if (se0) model_go(MSe0Wait);
      else if (j) model_go(MIdleWait);
    end else if (m_state == MSe0Wait) begin
      if (!se0) begin
        model_go(MActive);
        m_susp = 1'b0;
      end else if (reached(se0_time)) begin
        model_go(MRstHold);
        m_rst  = 1'b1;
        m_susp = 1'b0;
      end else m_run++;
    end else if (m_state == MRstHold) begin
      if (stable && line_state != 2'b00) model_go(MActive);
    end else if (m_state == MIdleWait) begin
      if (!j) model_go(MActive);
      else if (reached(idle_time)) begin
        model_go(MSuspend);
        m_susp = 1'b1;
      end else m_run++;
    end else if (m_state == MSuspend) begin
      if (k) model_go(MResumeWait);
      else if (se0) model_go(MSe0Wait);
    end else begin
      if (!k) model_go(MSuspend);
      else if (reached(k_time)) begin
        model_go(MActive);
        m_res  = 1'b1;
        m_susp = 1'b0;
      end else m_run++;
    end
  endfunction

  task automatic compare_all();
    chk("lm_state", 32'(lm_state), 32'(m_state));
    chk("bus_reset", 32'(bus_reset), 32'(m_rst));
    chk("suspend_det", 32'(suspend_det), 32'(m_susp));
    chk("resume_det", 32'(resume_det), 32'(m_res));
    chk("event_exclusive", 32'(bus_reset & resume_det), 32'd0);
  endtask

  task automatic step();
    model_step();
    @(posedge aon_clk);
    #1;
    compare_all();
  endtask

  initial begin
    int n_rst, at_rst, n_res, at_res, at_susp;
    bit susp_before;
    errors     = 0;
    checks     = 0;
    aon_rst_n  = 1'b0;
    sw_rst     = 1'b0;
    line_state = 2'b00;
    stable     = 1'b0;
    se0_time   = W'(10);
    idle_time  = W'(20);
    k_time     = W'(5);
    model_clear();

    // Reset state while aon_rst_n is held low.
    #12;
    chk("rst_lm_state", 32'(lm_state), 32'd0);
    chk("rst_bus_reset", 32'(bus_reset), 32'd0);
    chk("rst_suspend", 32'(suspend_det), 32'd0);
    chk("rst_resume", 32'(resume_det), 32'd0);
    #5 aon_rst_n = 1'b1;
    stable = 1'b1;

    // SE0 held 30 cycles: one bus_reset, threshold+1 edges after the first
    // cycle spent in SE0_WAIT (edge 12 counting the entry edge as 1).
    n_rst = 0; at_rst = 0;
    line_state = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus_reset) begin n_rst++; at_rst = i; end
    end
    chk("se0_pulse_count", 32'(n_rst), 32'd1);
    chk("se0_pulse_edge", 32'(at_rst), 32'd12);
    chk("rst_hold_state", 32'(lm_state), 32'(MRstHold));
    line_state = 2'b10;
    step();
    chk("rst_hold_exit", 32'(lm_state), 32'(MActive));

    // Short SE0 then J: no reset, timing of J starts afresh.
    n_rst = 0;
    line_state = 2'b00;
    for (int i = 0; i < 6; i++) begin step(); if (bus_reset) n_rst++; end
    line_state = 2'b10;
    step();
    step();
    chk("short_se0_no_reset", 32'(n_rst), 32'd0);
    chk("short_se0_idle_wait", 32'(lm_state), 32'(MIdleWait));

    // Suspend after idle_time, then resume after k_time.
    line_state = 2'b01;
    step();
    line_state = 2'b10;
    at_susp = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (suspend_det && at_susp == 0) at_susp = i;
    end
    chk("suspend_edge", 32'(at_susp), 32'd22);
    chk("suspend_level", 32'(suspend_det), 32'd1);
    line_state = 2'b01;
    n_res = 0; at_res = 0; susp_before = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 7) susp_before = suspend_det;
      step();
      if (resume_det) begin n_res++; at_res = i; end
      if (i == 7) chk("suspend_falls_with_resume", 32'(suspend_det), 32'd0);
    end
    chk("resume_count", 32'(n_res), 32'd1);
    chk("resume_edge", 32'(at_res), 32'd7);
    chk("suspend_before_resume", 32'(susp_before), 32'd1);

    // Short K in suspend returns to SUSPEND without resume.
    line_state = 2'b10;
    for (int i = 0; i < 25; i++) step();
    line_state = 2'b01;
    n_res = 0;
    for (int i = 0; i < 3; i++) begin step(); if (resume_det) n_res++; end
    line_state = 2'b10;
    step();
    chk("short_k_state", 32'(lm_state), 32'(MSuspend));
    chk("short_k_suspend", 32'(suspend_det), 32'd1);
    chk("short_k_no_resume", 32'(n_res), 32'd0);

    // Software reset from SUSPEND.
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("swrst_state", 32'(lm_state), 32'd0);
    chk("swrst_suspend", 32'(suspend_det), 32'd0);

    // Stable drop at count 7 aborts SE0 timing; a fresh full SE0 still resets.
    line_state = 2'b00;
    for (int i = 0; i < 8; i++) step();
    stable = 1'b0;
    step();
    chk("stable_drop_state", 32'(lm_state), 32'(MActive));
    stable = 1'b1;
    n_rst = 0; at_rst = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus_reset) begin n_rst++; at_rst = i; end
    end
    chk("fresh_se0_count", 32'(n_rst), 32'd1);
    chk("fresh_se0_edge", 32'(at_rst), 32'd12);
    line_state = 2'b10;
    step();

    // Disabled SE0 detection: counter saturates, so raising the threshold to
    // all-ones fires on the very next compare.
    se0_time = '0;
    line_state = 2'b00;
    n_rst = 0;
    for (int i = 0; i < 300; i++) begin step(); if (bus_reset) n_rst++; end
    chk("disabled_no_pulse", 32'(n_rst), 32'd0);
    chk("disabled_state", 32'(lm_state), 32'(MSe0Wait));
    se0_time = W'(MAXC);
    step();
    chk("saturated_fire", 32'(bus_reset), 32'd1);
    line_state = 2'b10;
    step();

    // Asynchronous reset in the middle of RESUME_WAIT.
    se0_time = W'(10);
    for (int i = 0; i < 25; i++) step();
    line_state = 2'b01;
    step();
    step();
    chk("pre_async_state", 32'(lm_state), 32'(MResumeWait));
    #3 aon_rst_n = 1'b0;
    #1;
    chk("async_state", 32'(lm_state), 32'd0);
    chk("async_suspend", 32'(suspend_det), 32'd0);
    chk("async_bus_reset", 32'(bus_reset), 32'd0);
    chk("async_resume", 32'(resume_det), 32'd0);
    model_clear();
    #2 aon_rst_n = 1'b1;

    // Random line activity with thresholds changing under the counter.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        se0_time  = W'($urandom_range(0, 6));
        idle_time = W'($urandom_range(0, 6));
        k_time    = W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 9) == 0) line_state = 2'($urandom_range(0, 3));
      stable = ($urandom_range(0, 19) != 0);
      sw_rst = ($urandom_range(0, 199) == 0);
      step();
    end
    sw_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
